// File: rtl/iddmm_pkg.sv
// Shared constants for the IDDMM adder pipeline: default sizes and the per-segment width helper.
package iddmm_pkg;

  localparam int K_DEF   = 256;
  localparam int N_DEF   = 16;
  localparam int SEG_DEF = 4;

  // Guarded so a bad SEG reaches the top-level config check instead of dividing by zero.
  function automatic int seg_w(input int k, input int seg);
    return (seg > 0) ? (2 * k) / seg : 1;
  endfunction

endpackage

// File: rtl/iddmm_seg_add.sv
// One carry-pipeline segment: registered W-bit add with carry in/out and a load enable.
// CARRY_EN=0 drops the carry register and ties cout low.
module iddmm_seg_add
  import iddmm_pkg::*;
#(
  parameter int W        = seg_w(K_DEF, SEG_DEF),
  parameter bit CARRY_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  if (CARRY_EN) begin : g_co
    logic [W:0] full;
    assign full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  {cout, sum} <= '0;
      else if (en) {cout, sum} <= full;
    end
  end else begin : g_noco
    logic [W-1:0] part;
    assign part = a + b + W'(cin);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  sum <= '0;
      else if (en) sum <= part;
    end
    assign cout = 1'b0;
  end

endmodule

// File: rtl/iddmm_adder_pipe.sv
// iddmm_adder_pipe: 2K-bit adder split into SEG carry-pipelined segments with valid/ready flow control.
// Define IDDMM_ADDER_CARRY_OUT_EN to register the top-segment carry as carry_out.
module iddmm_adder_pipe
  import iddmm_pkg::*;
#(
  parameter int K      = K_DEF,
  parameter int N      = N_DEF,
  parameter int ADDR_W = $clog2(N),
  parameter int SEG    = SEG_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W:0]   j_cnt,
  input  logic [2*K-1:0]    adder_a,
  input  logic [K-1:0]      adder_b,
  input  logic              carry_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*K-1:0]    adder_result,
  output logic              carry_out
);

  localparam int W  = seg_w(K, SEG);
  localparam int DW = 2 * K;
`ifdef IDDMM_ADDER_CARRY_OUT_EN
  localparam bit TOP_CO = 1'b1;
`else
  localparam bit TOP_CO = 1'b0;
`endif

  if (SEG < 1 || (DW % SEG) != 0) begin : g_bad_cfg
    $error("iddmm_adder_pipe: SEG must be >= 1 and divide 2*K");
  end

  logic [SEG:0]   vld_pipe;
  logic [SEG:0]   ld;
  logic           accept;
  logic [K:0]     bext;
  logic [DW-1:0]  a_q;
  logic [K:0]     b_q;
  logic [DW-1:0]  bfull;
  // x[s] is stage s's word: finished sums rotate in at the top, unused a segments sit at the bottom
  logic [DW-1:0]  x    [SEG+1];
  logic [W-1:0]   bdly [SEG];
  logic           co   [SEG:1];

  assign in_ready     = !(out_valid && !out_ready);
  assign accept       = in_valid && in_ready;
  assign bext         = {1'b0, adder_b} + (K+1)'((j_cnt == (ADDR_W+1)'(N)) && carry_in);
  assign out_valid    = vld_pipe[SEG];
  assign adder_result = x[SEG];
  assign carry_out    = co[SEG];

  // A stage may load when anything at or ahead of it is empty, so bubbles compress under a stall.
  for (genvar s = 0; s <= SEG; s++) begin : g_ld
    assign ld[s] = out_ready || !(&vld_pipe[SEG:s]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      if (ld[0]) vld_pipe[0] <= accept;
      for (int s = 1; s <= SEG; s++)
        if (ld[s]) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (ld[0]) begin
      a_q <= adder_a;
      b_q <= bext;
    end
  end

  assign x[0]  = a_q;
  assign bfull = DW'(b_q);

  // b segment i is consumed at stage i+1, so it waits i stages behind stage 0.
  for (genvar i = 0; i < SEG; i++) begin : g_bdly
    if (i == 0) begin : g_now
      assign bdly[0] = bfull[W-1:0];
    end else begin : g_dly
      logic [i-1:0][W-1:0] sr;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sr <= '0;
        end else begin
          if (ld[1]) sr[0] <= bfull[i*W +: W];
          for (int k = 1; k < i; k++)
            if (ld[k+1]) sr[k] <= sr[k-1];
        end
      end
      assign bdly[i] = sr[i-1];
    end
  end

  for (genvar s = 1; s <= SEG; s++) begin : g_st
    logic         seg_cin;
    logic [W-1:0] sum;

    if (s == 1) begin : g_c0
      assign seg_cin = 1'b0;
    end else begin : g_cn
      assign seg_cin = co[s-1];
    end

    iddmm_seg_add #(
      .W        (W),
      .CARRY_EN ((s < SEG) || TOP_CO)
    ) u_add (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (ld[s]),
      .a     (x[s-1][W-1:0]),
      .b     (bdly[s-1]),
      .cin   (seg_cin),
      .sum   (sum),
      .cout  (co[s])
    );

    if (SEG > 1) begin : g_rot
      logic [DW-W-1:0] xr;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      xr <= '0;
        else if (ld[s])  xr <= x[s-1][DW-1:W];
      end
      assign x[s] = {sum, xr};
    end else begin : g_one
      assign x[s] = sum;
    end
  end

endmodule

// File: tb/tb_iddmm_adder_pipe.sv
// Self-checking bench for iddmm_adder_pipe (K=256, N=16, SEG=4); scoreboard model uses plain wide addition.
module tb_iddmm_adder_pipe;

  localparam int K   = 256;
  localparam int N   = 16;
  localparam int SEG = 4;
  localparam int AW  = $clog2(N);
  localparam int DW  = 2 * K;
  localparam int LAT = SEG + 1;
`ifdef IDDMM_ADDER_CARRY_OUT_EN
  localparam bit CO_EN = 1'b1;
`else
  localparam bit CO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW:0]   j_cnt = '0;
  logic [DW-1:0] adder_a = '0;
  logic [K-1:0]  adder_b = '0;
  logic          carry_in = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] adder_result;
  logic          carry_out;

  always #5 clk = ~clk;

  iddmm_adder_pipe #(.K(K), .N(N), .ADDR_W(AW), .SEG(SEG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .j_cnt(j_cnt), .adder_a(adder_a), .adder_b(adder_b), .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready), .adder_result(adder_result),
    .carry_out(carry_out)
  );

  typedef struct {
    logic [DW-1:0] a;
    logic [K-1:0]  b;
    logic          cin;
    logic [AW:0]   j;
    logic [DW-1:0] res;
    logic          co;
  } vec_t;

  typedef struct {
    logic [DW-1:0] res;
    logic          co;
    int            cyc;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   n_out = 0;
  int   stall_seen = 0;
  bit   lat_chk = 1'b0;
  bit   prev_stall = 1'b0;
  logic [DW-1:0] prev_res = '0;
  exp_t sbq[$];
  vec_t tv[8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference: the full (2K+1)-bit sum; carry_in counts only on the last iteration.
  function automatic logic [DW:0] model(input logic [DW-1:0] a, input logic [K-1:0] b,
                                        input logic cin, input logic [AW:0] j);
    logic [DW:0] s;
    s = {1'b0, a} + (DW+1)'(b);
    if (int'(j) == N) s = s + (DW+1)'(cin);
    return s;
  endfunction

  always @(negedge clk) begin
    exp_t        e;
    logic [DW:0] s;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        chk("stall_hold_valid", out_valid, 1'b1);
        chk("stall_hold_result", adder_result, prev_res);
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = adder_result;
      if (prev_stall) stall_seen++;
      if (in_valid && in_ready) begin
        s = model(adder_a, adder_b, carry_in, j_cnt);
        e.res = s[DW-1:0];
        e.co  = CO_EN ? s[DW] : 1'b0;
        e.cyc = cyc;
        sbq.push_back(e);
        n_acc++;
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_out got=valid result=%0h exp=no_output", adder_result);
        end else begin
          e = sbq.pop_front();
          chk("sb_result", adder_result, e.res);
          chk("sb_carry", carry_out, e.co);
          if (lat_chk) chk("latency", cyc - e.cyc, LAT);
          n_out++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [DW-1:0] a, input logic [K-1:0] b, input logic cin,
                       input logic [AW:0] j, input logic v);
    adder_a  = a;
    adder_b  = b;
    carry_in = cin;
    j_cnt    = j;
    in_valid = v;
  endtask

  function automatic logic [DW-1:0] rnd_wide();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic wait_out(input string name);
    int w;
    w = 0;
    while (!out_valid && w < 20) begin
      tick();
      w++;
    end
    if (!out_valid) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout got=no_out_valid exp=out_valid", name);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] ones, ones128, p128, p256, hi_ones;
    logic [DW-1:0] ops_a [8];
    logic [K-1:0]  ops_b [8];
    int base_acc, base_out, ov_seen;

    ones    = '1;
    ones128 = '0; ones128[127:0] = '1;
    p128    = '0; p128[128] = 1'b1;
    p256    = '0; p256[256] = 1'b1;
    hi_ones = '0; hi_ones[DW-1:K] = '1;

    tv[0] = '{a: 512'd5, b: 256'd7, cin: 1'b1, j: 5'd3,  res: 512'd12, co: 1'b0};
    tv[1] = '{a: 512'd5, b: 256'd7, cin: 1'b1, j: 5'd16, res: 512'd13, co: 1'b0};
    tv[2] = '{a: ones128, b: 256'd1, cin: 1'b0, j: 5'd0, res: p128, co: 1'b0};
    tv[3] = '{a: ones, b: 256'd1, cin: 1'b0, j: 5'd0, res: '0, co: 1'b1};
    tv[4] = '{a: '0, b: '1, cin: 1'b1, j: 5'd16, res: p256, co: 1'b0};
    tv[5] = '{a: hi_ones, b: '1, cin: 1'b1, j: 5'd16, res: '0, co: 1'b1};
    tv[6] = '{a: '0, b: '0, cin: 1'b1, j: 5'd15, res: '0, co: 1'b0};
    tv[7] = '{a: 512'd5, b: 256'd7, cin: 1'b0, j: 5'd16, res: 512'd12, co: 1'b0};

    // Reset state
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_result", adder_result, '0);
    chk("reset_carry", carry_out, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();

    // Directed table, one operation at a time
    lat_chk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(tv[i].a, tv[i].b, tv[i].cin, tv[i].j, 1'b1);
      tick();
      in_valid = 1'b0;
      wait_out($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_result", i), adder_result, tv[i].res);
      chk($sformatf("vec%0d_carry", i), carry_out, CO_EN ? tv[i].co : 1'b0);
      tick();
    end
    lat_chk = 1'b0;

    // 8 back-to-back with a 3-cycle output stall mid-stream
    for (int i = 0; i < 8; i++) begin
      ops_a[i] = rnd_wide();
      ops_b[i] = K'(rnd_wide());
    end
    base_acc = n_acc;
    base_out = n_out;
    stall_seen = 0;
    for (int t = 0; t < 60 && (n_out - base_out) < 8; t++) begin
      out_ready = !(t >= 6 && t <= 8);
      if (n_acc - base_acc < 8)
        drive(ops_a[n_acc-base_acc], ops_b[n_acc-base_acc], 1'b1, 5'd16, 1'b1);
      else
        in_valid = 1'b0;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("burst_accepted", n_acc - base_acc, 8);
    chk("burst_delivered", n_out - base_out, 8);
    chk("burst_stall_cycles", stall_seen, 3);
    chk("burst_sb_empty", sbq.size(), 0);

    // Randomized traffic with random backpressure
    for (int t = 0; t < 400; t++) begin
      drive(rnd_wide(), ($urandom_range(0, 7) == 0) ? '1 : K'(rnd_wide()), 1'($urandom),
            ($urandom_range(0, 1) == 1) ? 5'(N) : 5'($urandom_range(0, 31)),
            $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) adder_a = '1;
      out_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int w = 0; w < 50 && sbq.size() > 0; w++) tick();
    chk("random_drained", sbq.size(), 0);

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) begin
      drive(rnd_wide(), K'(rnd_wide()), 1'b1, 5'd16, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", out_valid, 1'b0);
    chk("midreset_result", adder_result, '0);
    chk("midreset_carry", carry_out, 1'b0);
    chk("midreset_in_ready", in_ready, 1'b1);
    sbq.delete();
    tick();
    tick();
    rst_n = 1'b1;
    ov_seen = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (out_valid) ov_seen++;
    end
    chk("post_reset_no_out", ov_seen, 0);
    drive(512'd5, 256'd7, 1'b1, 5'd16, 1'b1);
    tick();
    in_valid = 1'b0;
    wait_out("post_reset");
    chk("post_reset_result", adder_result, 512'd13);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
